// File: rtl/fu_mul_pipe.sv
// Pipelined RV32M-style multiply unit: one op per cycle, tag carried with each op,
// output backpressure stalls the whole pipe, flush kills everything in flight.
module fu_mul_pipe #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned LATENCY = 6,
   parameter int unsigned TAG_W   = 4,
   localparam int unsigned CNT_W  = $clog2(LATENCY + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [XLEN-1:0]  a,
   input  logic [XLEN-1:0]  b,
   input  logic [TAG_W-1:0] tag,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_res,
   output logic [TAG_W-1:0] out_tag,
   output logic [CNT_W-1:0] occupancy
);

   localparam int unsigned PW = 2 * XLEN;

   logic [LATENCY-1:0] vld_q;
   logic [XLEN-1:0]    res_q [LATENCY];
   logic [TAG_W-1:0]   tag_q [LATENCY];

   logic            advance;
   logic            accept;
   logic            out_hs;
   logic            a_sgn;
   logic            b_sgn;
   logic [PW-1:0]   a_w;
   logic [PW-1:0]   b_w;
   logic [PW-1:0]   prod;
   logic [XLEN-1:0] res_d;

   assign out_valid = vld_q[LATENCY-1];
   assign out_res   = res_q[LATENCY-1];
   assign out_tag   = tag_q[LATENCY-1];

   // Whole pipe moves together; flush dominates the output handshake.
   assign advance  = ~out_valid | out_ready;
   assign in_ready = advance & ~flush;
   assign accept   = in_valid & in_ready;
   assign out_hs   = out_valid & out_ready & ~flush;

   // Single multiply at entry. Operands are extended straight to 2*XLEN bits:
   // the low 2*XLEN bits of the product are all any variant needs, so the
   // extra sign bits of the (XLEN+1)-bit formulation never have to exist.
   always_comb begin
      a_sgn = ((op == 2'b01) || (op == 2'b10)) & a[XLEN-1];
      b_sgn = (op == 2'b01) & b[XLEN-1];
      a_w   = {{XLEN{a_sgn}}, a};
      b_w   = {{XLEN{b_sgn}}, b};
      prod  = a_w * b_w;
      res_d = (op == 2'b00) ? prod[XLEN-1:0] : prod[PW-1:XLEN];
   end

   // Stage valid bits: shift on advance, cleared by flush or reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
      end else if (flush) begin
         vld_q <= '0;
      end else if (advance) begin
         vld_q[0] <= accept;
         for (int i = 1; i < int'(LATENCY); i++) begin
            vld_q[i] <= vld_q[i-1];
         end
      end
   end

   // Result/tag retiming registers; hold whenever the output is stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(LATENCY); i++) begin
            res_q[i] <= '0;
            tag_q[i] <= '0;
         end
      end else if (advance) begin
         res_q[0] <= res_d;
         tag_q[0] <= tag;
         for (int i = 1; i < int'(LATENCY); i++) begin
            res_q[i] <= res_q[i-1];
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   // Occupancy tracks accepts minus completed output handshakes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occupancy <= '0;
      end else if (flush) begin
         occupancy <= '0;
      end else begin
         case ({accept, out_hs})
            2'b10:   occupancy <= occupancy + CNT_W'(1);
            2'b01:   occupancy <= occupancy - CNT_W'(1);
            default: occupancy <= occupancy;
         endcase
      end
   end

endmodule

// File: tb/tb_fu_mul_pipe.sv
// Scoreboard bench for fu_mul_pipe: expected results queued at accept,
// compared (value, tag, latency) at the output; occupancy tracked every cycle.
module tb_fu_mul_pipe;

   parameter int unsigned LAT   = 6;
   localparam int unsigned XL   = 32;
   localparam int unsigned TW   = 4;
   localparam int unsigned CW   = $clog2(LAT + 1);

   typedef struct {
      logic [XL-1:0] res;
      logic [TW-1:0] tag;
      int            cyc;
      int            stalls;
   } exp_t;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [1:0]    op;
   logic [XL-1:0] a;
   logic [XL-1:0] b;
   logic [TW-1:0] tag;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [XL-1:0] out_res;
   logic [TW-1:0] out_tag;
   logic [CW-1:0] occupancy;

   exp_t q[$];
   int   n_chk     = 0;
   int   n_pass    = 0;
   int   cyc       = 0;
   int   stall_cnt = 0;
   bit   rnd_done  = 0;

   fu_mul_pipe #(.XLEN(XL), .LATENCY(LAT), .TAG_W(TW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .tag       (tag),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res),
      .out_tag   (out_tag),
      .occupancy (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference multiply done in 64-bit integer arithmetic.
   function automatic logic [XL-1:0] model(input logic [1:0] o, input logic [XL-1:0] x,
                                           input logic [XL-1:0] y);
      longint      sx;
      longint      sy;
      longint      uy;
      logic [63:0] ux;
      logic [63:0] p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      uy = longint'({32'h0, y});
      ux = {32'h0, x};
      case (o)
         2'b00, 2'b01: p = 64'(sx * sy);
         2'b10:        p = 64'(sx * uy);
         default:      p = ux * {32'h0, y};
      endcase
      return (o == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   // Scoreboard: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         q.delete();
      end else begin
         check("occupancy", 64'(occupancy), 64'(q.size()));
         if (out_valid) begin
            if (q.size() == 0) begin
               check("spurious_out", 64'(out_valid), 64'(0));
            end else begin
               check("out_res", 64'(out_res), 64'(q[0].res));
               check("out_tag", 64'(out_tag), 64'(q[0].tag));
               if (out_ready && !flush) begin
                  e = q.pop_front();
                  check("latency", 64'(cyc), 64'(e.cyc + int'(LAT) + stall_cnt - e.stalls));
               end
            end
         end
         if (flush) q.delete();
         if (in_valid && in_ready) begin
            e.res    = model(op, a, b);
            e.tag    = tag;
            e.cyc    = cyc;
            e.stalls = stall_cnt;
            q.push_back(e);
         end
         if (out_valid && !out_ready) stall_cnt++;
      end
   end

   task automatic send(input logic [1:0] o, input logic [XL-1:0] x, input logic [XL-1:0] y,
                       input logic [TW-1:0] t);
      int n = 0;
      in_valid = 1'b1;
      op = o; a = x; b = y; tag = t;
      @(negedge clk);
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) check("send_timeout", 64'(0), 64'(1));
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() > 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) check("drain_timeout", 64'(q.size()), 64'(0));
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; op = 2'b00; a = '0; b = '0; tag = '0;
      flush = 1'b0; out_ready = 1'b1;
      #2;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_occupancy", 64'(occupancy), 64'(0));
      check("rst_out_res", 64'(out_res), 64'(0));
      check("rst_out_tag", 64'(out_tag), 64'(0));
      @(negedge clk);
      #2 rst = 1'b0;
      #1 check("in_ready_after_rst", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;

      // Basic MUL
      send(2'b00, 32'd7, 32'd6, 4'd3);
      drain();

      // All variants at the sign boundaries
      send(2'b00, 32'hFFFF_FFFF, 32'h2, 4'd1);
      send(2'b01, 32'hFFFF_FFFF, 32'h2, 4'd2);
      send(2'b10, 32'hFFFF_FFFF, 32'h2, 4'd3);
      send(2'b11, 32'hFFFF_FFFF, 32'h2, 4'd4);
      send(2'b01, 32'h8000_0000, 32'h8000_0000, 4'd5);
      send(2'b11, 32'h8000_0000, 32'h8000_0000, 4'd6);
      drain();
      check("mulh_lit", 64'(model(2'b01, 32'hFFFF_FFFF, 32'h2)), 64'hFFFF_FFFF);
      check("mulhu_lit", 64'(model(2'b11, 32'hFFFF_FFFF, 32'h2)), 64'h1);

      // Back-to-back at full throughput
      for (int i = 0; i < 10; i++) send(2'b00, 32'(i), 32'(i + 1), 4'(i));
      drain();

      // Backpressure: fill the pipe with the output stalled, then release
      out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < int'(LAT) + 2; i++)
               send(2'(i % 4), 32'(1000 + i), 32'(i + 3), 4'(i));
         end
         begin
            repeat (LAT + 4) @(negedge clk);
            check("full_occupancy", 64'(occupancy), 64'(LAT));
            check("full_in_ready", 64'(in_ready), 64'(0));
            check("full_out_valid", 64'(out_valid), 64'(1));
            @(posedge clk);
            #1 out_ready = 1'b1;
            #1 check("release_in_ready", 64'(in_ready), 64'(1));
         end
      join
      drain();

      // Flush with ops in flight, then a fresh op
      for (int i = 0; i < 4; i++) send(2'b11, 32'(i + 50), 32'hDEAD_BEEF, 4'(i + 8));
      flush = 1'b1;
      #1 check("flush_in_ready", 64'(in_ready), 64'(0));
      @(posedge clk);
      #1 flush = 1'b0;
      check("post_flush_valid", 64'(out_valid), 64'(0));
      check("post_flush_occ", 64'(occupancy), 64'(0));
      send(2'b10, 32'hF000_0001, 32'hF000_0003, 4'd12);
      drain();
      idle(int'(LAT) + 2);

      // Random ops under random backpressure
      rnd_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 40; i++)
               send(2'($urandom_range(0, 3)), $urandom, $urandom, 4'(i));
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1 out_ready = ($urandom_range(0, 2) != 0);
            end
         end
      join
      out_ready = 1'b1;
      drain();

      // Asynchronous reset with ops in flight
      for (int i = 0; i < 3; i++) send(2'b00, 32'(i + 9), 32'd11, 4'(i));
      #1 rst = 1'b1;
      #1;
      check("async_rst_valid", 64'(out_valid), 64'(0));
      check("async_rst_occ", 64'(occupancy), 64'(0));
      @(posedge clk);
      #2 rst = 1'b0;
      idle(int'(LAT) + 4);
      check("post_rst_empty", 64'(q.size()), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
